// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_enable_gen
// Brief    : Multi-channel programmable clock-enable generator. Each channel
//            has its own reload value and mode and emits a registered tick.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module clk_enable_gen #(
    parameter int               WIDTH     = 12,
    parameter int               CHANNELS  = 4,
    parameter logic [WIDTH-1:0] DIV_RESET = '0,
    localparam int              CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [WIDTH-1:0]          cfg_div,
    input  logic [1:0]                cfg_mode,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [CHANNELS-1:0]       ch_clear,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS*WIDTH-1:0] count
);

    localparam logic [1:0]       c_MODE_ONESHOT = 2'b01;
    localparam logic [1:0]       c_MODE_UP      = 2'b10;
    localparam logic [1:0]       c_MODE_RESET   = 2'b00;
    localparam logic [WIDTH-1:0] c_ALL_ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO         = '0;
    localparam logic [WIDTH-1:0] c_ONE          = WIDTH'(1);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        // Channel select values past CHANNELS-1 match no channel, so such
        // writes fall through without touching any state.
        localparam logic [CH_W-1:0] c_IDX = CH_W'(k);

        logic [WIDTH-1:0] r_div;
        logic [WIDTH-1:0] r_count;
        logic [1:0]       r_mode;
        logic             r_tick;
        logic             r_done;

        logic [WIDTH-1:0] w_div_nxt;
        logic [WIDTH-1:0] w_count_nxt;
        logic [1:0]       w_mode_nxt;
        logic             w_tick_nxt;
        logic             w_done_nxt;
        logic             w_wr_hit;

        assign w_wr_hit = cfg_we && (cfg_ch == c_IDX);

        always_comb begin
            w_div_nxt   = r_div;
            w_mode_nxt  = r_mode;
            w_count_nxt = r_count;
            w_tick_nxt  = 1'b0;
            w_done_nxt  = r_done;

            if (w_wr_hit) begin
                w_div_nxt   = cfg_div;
                w_mode_nxt  = cfg_mode;
                w_count_nxt = cfg_div;
                w_done_nxt  = 1'b0;
            end else if (ch_clear[k]) begin
                w_count_nxt = r_div;
                w_done_nxt  = 1'b0;
            end else if (ch_en[k]) begin
                case (r_mode)
                    c_MODE_ONESHOT: begin
                        // Once done, the channel parks at zero until re-armed.
                        if (!r_done) begin
                            if (r_count == c_ZERO) begin
                                w_tick_nxt = 1'b1;
                                w_done_nxt = 1'b1;
                            end else begin
                                w_count_nxt = r_count - c_ONE;
                            end
                        end
                    end
                    c_MODE_UP: begin
                        // Reload at all-ones so the increment never wraps.
                        if (r_count == c_ALL_ONES) begin
                            w_count_nxt = r_div;
                            w_tick_nxt  = 1'b1;
                        end else begin
                            w_count_nxt = r_count + c_ONE;
                        end
                    end
                    default: begin
                        if (r_count == c_ZERO) begin
                            w_count_nxt = r_div;
                            w_tick_nxt  = 1'b1;
                        end else begin
                            w_count_nxt = r_count - c_ONE;
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_div   <= DIV_RESET;
                r_mode  <= c_MODE_RESET;
                r_count <= DIV_RESET;
                r_tick  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                r_div   <= w_div_nxt;
                r_mode  <= w_mode_nxt;
                r_count <= w_count_nxt;
                r_tick  <= w_tick_nxt;
                r_done  <= w_done_nxt;
            end
        end

        assign tick[k]                  = r_tick;
        assign done[k]                  = r_done;
        assign count[k*WIDTH +: WIDTH]  = r_count;
    end

endmodule
`default_nettype wire
